data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words; a power of two, 4..65536.
REQ-002 SHALL have parameter INIT_FILE, default "": optional $readmemh image, loaded at elaboration only when the string is non-empty.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_funct3, input, 3 bits: RV32 size code. 0=B, 1=H, 2=W, 4=BU, 5=HU.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load result, extended; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request faulted.

Function
REQ-015 SHALL accept a request on any rising edge where req_valid && req_ready.
REQ-016 SHALL implement a two-state FSM:
- IDLE -> RESP on acceptance.
- RESP -> IDLE when rsp_ready and no new acceptance that cycle.
- RESP -> RESP when rsp_ready and a new acceptance happen in the same cycle.
REQ-017 SHALL drive req_ready = (state==IDLE) || rsp_ready, combinationally, giving back-to-back throughput of one request per cycle.
REQ-018 SHALL assert rsp_valid exactly 1 cycle after acceptance.
REQ-019 SHALL hold rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
REQ-020 SHALL flag an error for a misaligned access: funct3 H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-021 SHALL flag an error for an illegal funct3: 3, 6, 7 for any request, or 4, 5 for a store.
REQ-022 SHALL flag an error for an out-of-range access: addr[31:2] >= MEM_WORDS.
REQ-023 SHALL, on an erroring request, leave memory unmodified and respond with rsp_err=1 and rsp_rdata=0.
REQ-024 SHALL, on an accepted legal store, write memory at the accept edge using byte enables:
- B: lane addr[1:0].
- H: lanes {addr[1],0} and {addr[1],1}.
- W: all four lanes.
REQ-025 SHALL take store data from req_wdata[7:0] for B, req_wdata[15:0] for H, and all 32 bits for W.
REQ-026 SHALL read a load from the addressed word at the accept edge, then select the lane and extend it:
- B: sign-extend the byte.
- BU: zero-extend the byte.
- H: sign-extend the halfword.
- HU: zero-extend the halfword.
- W: pass the word unchanged.
REQ-027 SHALL apply a store accepted in cycle N before a load accepted in cycle N+1, so read-after-write returns the new data.
REQ-028 SHALL drive rsp_rdata=0 for a legal store, with rsp_err=0.
REQ-029 SHALL ignore req_we, req_addr, req_funct3 and req_wdata while req_valid=0 or req_ready=0.
REQ-030 SHALL infer the memory array as synchronous-read block RAM; the lane-select and extension mux is the only logic after the RAM.

Reset
REQ-031 SHALL, while rst=1, force state=IDLE, rsp_valid=0, rsp_rdata=0 and rsp_err=0, with req_ready=1 after the edge.
REQ-032 SHALL block acceptance while rst=1: no memory write occurs even if req_valid=1.
REQ-033 SHALL, on rst asserted mid-response, discard the pending response; it is never presented.
REQ-034 SHALL NOT clear memory contents on rst.

Verification
REQ-035 SHALL be covered by this scenario: SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> rsp_rdata=0xDEADBEEF, rsp_err=0, 1 cycle latency each.
REQ-036 SHALL be covered by this scenario: with word 0x8 = 0xDEADBEEF, issue LB 0xB, LBU 0xB, LH 0xA, LHU 0xA -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
REQ-037 SHALL be covered by this scenario: SB 0x9 data 0x12, then SH 0xE data 0x3456 over zeros, then LW 0x8 and LW 0xC -> 0x00001200 and 0x34560000.
REQ-038 SHALL be covered by this scenario: LW 0x6, SH 0x3, funct3=3, and LW 4*MEM_WORDS -> rsp_err=1 and rsp_rdata=0 each; the target word is unchanged afterwards.
REQ-039 SHALL be covered by this scenario: rsp_ready held 0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp_* stable; then rsp_ready=1 -> one accept per cycle back-to-back, with no lost or duplicated responses.
REQ-040 SHALL be covered by this scenario: rst pulsed for 1 cycle while rsp_valid=1 -> next cycle rsp_valid=0 and req_ready=1; a later LW returns pre-reset memory contents.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one valid/ready request port, one valid/ready
// response port, byte-addressed RV32 loads/stores into a word-wide RAM.
// Responses appear one cycle after acceptance; a new request can be taken
// in the same cycle the current response is consumed.
module data_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata_word;
  logic        r_err;
  logic        r_is_load;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;

  logic          w_accept;
  logic          w_illegal;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_err;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rdata;

  // Handshake: reset blocks acceptance even though req_ready may read high.
  assign req_ready = (r_state == S_IDLE) || rsp_ready;
  assign w_accept  = req_valid && req_ready && !rst;
  assign rsp_valid = (r_state == S_RESP);
  assign w_idx     = req_addr[AW+1:2];

  // Request classification: illegal size code, misalignment, range.
  always_comb begin
    w_illegal      = 1'b0;
    w_misaligned   = 1'b0;
    w_out_of_range = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: w_illegal = req_we && (req_funct3 == F3_BU);
      F3_H, F3_HU: begin
        w_illegal    = req_we && (req_funct3 == F3_HU);
        w_misaligned = req_addr[0];
      end
      F3_W:        w_misaligned = (req_addr[1:0] != 2'b00);
      default:     w_illegal = 1'b1;
    endcase
    w_out_of_range = ({2'b00, req_addr[31:2]} >= LP_WORDS);
    w_err          = w_illegal || w_misaligned || w_out_of_range;
  end

  // Store byte enables and lane-replicated store data.
  always_comb begin
    w_be        = '0;
    w_wdata_rep = req_wdata;
    case (req_funct3)
      F3_B: begin
        w_be[req_addr[1:0]] = 1'b1;
        w_wdata_rep         = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      F3_W:    w_be = '1;
      default: w_be = '0;
    endcase
    w_wr_en = w_accept && req_we && !w_err;
    w_rd_en = w_accept && !req_we && !w_err;
  end

  // RAM: byte-enabled write and registered read, both on the accept edge.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
    end
    if (w_rd_en) begin
      r_rdata_word <= r_mem[w_idx];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = w_accept ? S_RESP : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response attributes captured at acceptance, held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_is_load <= 1'b0;
      r_f3      <= '0;
      r_lane    <= '0;
    end else if (w_accept) begin
      r_err     <= w_err;
      r_is_load <= !req_we && !w_err;
      r_f3      <= req_funct3;
      r_lane    <= req_addr[1:0];
    end
  end

  // Lane select and extension after the RAM output register.
  always_comb begin
    w_byte  = r_rdata_word[8*r_lane +: 8];
    w_half  = r_lane[1] ? r_rdata_word[31:16] : r_rdata_word[15:0];
    w_rdata = '0;
    case (r_f3)
      F3_B:    w_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_rdata = {24'h0, w_byte};
      F3_H:    w_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   w_rdata = {16'h0, w_half};
      F3_W:    w_rdata = r_rdata_word;
      default: w_rdata = '0;
    endcase
    rsp_rdata = r_is_load ? w_rdata : '0;
    rsp_err   = r_err;
  end

endmodule
